// File: rtl/axi4_lite_cmd_mst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_cmd_mst_pkg
//  Description : Shared types for the AXI4-Lite command master. Holds the FSM
//                state enum, the AXI response codes and width-parametrised
//                command/response struct typedef macros.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================

// Struct typedef macros: packed structs whose widths follow the master's
// parameters. Usage: typedef `AXI4_LITE_CMD_MST_CMD_T(AW, DW) cmd_t;
`define AXI4_LITE_CMD_MST_CMD_T(AW, DW) \
  struct packed { \
    logic              is_wr; \
    logic [(AW)-1:0]   addr; \
    logic [2:0]        prot; \
    logic [(DW)-1:0]   wdata; \
    logic [(DW)/8-1:0] wstrb; \
  }

`define AXI4_LITE_CMD_MST_RSP_T(DW) \
  struct packed { \
    logic [(DW)-1:0] rdata; \
    logic [1:0]      resp; \
  }

package axi4_lite_cmd_mst_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_if
//  Description : AXI4-Lite bus bundle (AW, W, B, AR, R channels) with master
//                and slave modports.
//  Ports       : none; modports mst_port / slv_port
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi4_lite_if #(
  parameter int AXI4_LITE_ADDR_BIT_WIDTH = 4,
  parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
) ();

  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                            awprot;
  logic                                  awvalid;
  logic                                  awready;
  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   wdata;
  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                                  wvalid;
  logic                                  wready;
  logic [1:0]                            bresp;
  logic                                  bvalid;
  logic                                  bready;
  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                            arprot;
  logic                                  arvalid;
  logic                                  arready;
  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                            rresp;
  logic                                  rvalid;
  logic                                  rready;

  modport mst_port (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slv_port (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

endinterface
`default_nettype wire

// File: rtl/axi4_lite_cmd_mst_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_cmd_mst_wdog
//  Description : Transaction watchdog. Counts enabled cycles since the last
//                clear and flags expiry on the cycle the count reaches
//                TIMEOUT_CYCLES-1 while still enabled.
//  Ports       : i_clk, i_async_rst_n - clock, async active-low reset
//                i_clr   - restart the count at zero
//                i_en    - count this cycle (transaction outstanding)
//                o_expire- limit reached, abandon on the next edge
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_cmd_mst_wdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic i_clk,
  input  logic i_async_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int              C_CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [C_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != C_LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/axi4_lite_cmd_mst.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_cmd_mst
//  Description : AXI4-Lite master converting a command/response stream into
//                single read or write transactions, one outstanding at a
//                time. AW and W complete independently. All outputs are
//                registered. Define AXI4_LITE_CMD_MST_TIMEOUT_EN to enable a
//                watchdog that abandons a transaction after TIMEOUT_CYCLES.
//  Ports       : i_clk, i_async_rst_n         - clock, async active-low reset
//                i_cmd_* / o_cmd_ready        - command stream (valid/ready)
//                o_rsp_* / i_rsp_ready        - response stream (valid/ready)
//                if_m_axi4_lite               - AXI4-Lite master port
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_cmd_mst
  import axi4_lite_cmd_mst_pkg::*;
#(
  parameter int AXI4_LITE_ADDR_BIT_WIDTH = 4,
  parameter int AXI4_LITE_DATA_BIT_WIDTH = 32,
  parameter int TIMEOUT_CYCLES           = 256
) (
  input  logic                                  i_clk,
  input  logic                                  i_async_rst_n,
  input  logic                                  i_cmd_valid,
  output logic                                  o_cmd_ready,
  input  logic                                  i_cmd_is_wr,
  input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
  input  logic [2:0]                            i_cmd_prot,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                                  o_rsp_valid,
  input  logic                                  i_rsp_ready,
  output logic                                  o_rsp_is_wr,
  output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                            o_rsp_resp,
  output logic                                  o_rsp_timeout,
  axi4_lite_if.mst_port                         if_m_axi4_lite
);

  typedef `AXI4_LITE_CMD_MST_CMD_T(AXI4_LITE_ADDR_BIT_WIDTH, AXI4_LITE_DATA_BIT_WIDTH) cmd_t;
  typedef `AXI4_LITE_CMD_MST_RSP_T(AXI4_LITE_DATA_BIT_WIDTH) rsp_t;

  state_e r_state;
  cmd_t   r_cmd;
  rsp_t   r_rsp;
  logic   r_cmd_ready;
  logic   r_rsp_valid;
  logic   r_aw_done;
  logic   r_w_done;
  logic   r_awvalid;
  logic   r_wvalid;
  logic   r_bready;
  logic   r_arvalid;
  logic   r_rready;

  logic   w_accept;
  logic   w_aw_hs;
  logic   w_w_hs;

  assign w_accept = (r_state == IDLE) && i_cmd_valid && r_cmd_ready;
  assign w_aw_hs  = r_awvalid && if_m_axi4_lite.awready;
  assign w_w_hs   = r_wvalid && if_m_axi4_lite.wready;

`ifdef AXI4_LITE_CMD_MST_TIMEOUT_EN
  logic r_rsp_timeout;
  logic w_wdog_en;
  logic w_expire;

  assign w_wdog_en = (r_state == WR_AW_W) || (r_state == WR_B) ||
                     (r_state == RD_AR)   || (r_state == RD_R);

  axi4_lite_cmd_mst_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .i_clk         (i_clk),
    .i_async_rst_n (i_async_rst_n),
    .i_clr         (w_accept),
    .i_en          (w_wdog_en),
    .o_expire      (w_expire)
  );

  assign o_rsp_timeout = r_rsp_timeout;
`else
  assign o_rsp_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_rsp       <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
`ifdef AXI4_LITE_CMD_MST_TIMEOUT_EN
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
`ifdef AXI4_LITE_CMD_MST_TIMEOUT_EN
      // Watchdog wins over any handshake in the same cycle: the bus
      // transaction is abandoned and a SLVERR response is reported.
      if (w_expire) begin
        r_awvalid     <= 1'b0;
        r_wvalid      <= 1'b0;
        r_bready      <= 1'b0;
        r_arvalid     <= 1'b0;
        r_rready      <= 1'b0;
        r_rsp.rdata   <= '0;
        r_rsp.resp    <= RESP_SLVERR;
        r_rsp_timeout <= 1'b1;
        r_rsp_valid   <= 1'b1;
        r_state       <= RSP;
      end else begin
`endif
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_cmd.is_wr <= i_cmd_is_wr;
            r_cmd.addr  <= i_cmd_addr;
            r_cmd.prot  <= i_cmd_prot;
            r_cmd.wdata <= i_cmd_wdata;
            r_cmd.wstrb <= i_cmd_wstrb;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
`ifdef AXI4_LITE_CMD_MST_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
`endif
            if (i_cmd_is_wr) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR_AW_W;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= RD_AR;
            end
          end else begin
            // Also covers the first edge after reset release.
            r_cmd_ready <= 1'b1;
          end
        end

        WR_AW_W: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // Look ahead at this cycle's handshakes so B readiness is not
          // delayed a cycle when the last of AW/W completes.
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            r_bready <= 1'b1;
            r_state  <= WR_B;
          end
        end

        WR_B: begin
          if (if_m_axi4_lite.bvalid) begin
            r_bready    <= 1'b0;
            r_rsp.rdata <= '0;
            r_rsp.resp  <= if_m_axi4_lite.bresp;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end
        end

        RD_AR: begin
          if (if_m_axi4_lite.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_R;
          end
        end

        RD_R: begin
          if (if_m_axi4_lite.rvalid) begin
            r_rready    <= 1'b0;
            r_rsp.rdata <= if_m_axi4_lite.rdata;
            r_rsp.resp  <= if_m_axi4_lite.rresp;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end
        end

        RSP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
`ifdef AXI4_LITE_CMD_MST_TIMEOUT_EN
      end
`endif
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_is_wr = r_cmd.is_wr;
  assign o_rsp_rdata = r_rsp.rdata;
  assign o_rsp_resp  = r_rsp.resp;

  assign if_m_axi4_lite.awaddr  = r_cmd.addr;
  assign if_m_axi4_lite.awprot  = r_cmd.prot;
  assign if_m_axi4_lite.awvalid = r_awvalid;
  assign if_m_axi4_lite.wdata   = r_cmd.wdata;
  assign if_m_axi4_lite.wstrb   = r_cmd.wstrb;
  assign if_m_axi4_lite.wvalid  = r_wvalid;
  assign if_m_axi4_lite.bready  = r_bready;
  assign if_m_axi4_lite.araddr  = r_cmd.addr;
  assign if_m_axi4_lite.arprot  = r_cmd.prot;
  assign if_m_axi4_lite.arvalid = r_arvalid;
  assign if_m_axi4_lite.rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_cmd_mst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_lite_cmd_mst
//  Description : Directed self-checking bench for axi4_lite_cmd_mst. Inputs
//                change on the falling edge, outputs are sampled on the
//                falling edge. The timeout scenario is built only when
//                AXI4_LITE_CMD_MST_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_cmd_mst;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_is_wr;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_prot;
  logic [DW-1:0] cmd_wdata;
  logic [DW/8-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_is_wr, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;
  int n_b      = 0;

  always #5 clk = ~clk;

  axi4_lite_if #(.AXI4_LITE_ADDR_BIT_WIDTH(AW), .AXI4_LITE_DATA_BIT_WIDTH(DW)) axi ();

  axi4_lite_cmd_mst #(
    .AXI4_LITE_ADDR_BIT_WIDTH (AW),
    .AXI4_LITE_DATA_BIT_WIDTH (DW),
    .TIMEOUT_CYCLES           (TO)
  ) u_dut (
    .i_clk          (clk),
    .i_async_rst_n  (rst_n),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_is_wr    (cmd_is_wr),
    .i_cmd_addr     (cmd_addr),
    .i_cmd_prot     (cmd_prot),
    .i_cmd_wdata    (cmd_wdata),
    .i_cmd_wstrb    (cmd_wstrb),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_is_wr    (rsp_is_wr),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_resp     (rsp_resp),
    .o_rsp_timeout  (rsp_timeout),
    .if_m_axi4_lite (axi)
  );

  // Handshake counters, sampled with pre-edge values.
  always @(posedge clk) begin
    if (rsp_valid && rsp_ready) n_rsp++;
    if (axi.bvalid && axi.bready) n_b++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents a command for exactly one accepting edge (cmd_ready assumed high).
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [2:0] p,
                          input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    cmd_valid = 1'b1; cmd_is_wr = wr; cmd_addr = a; cmd_prot = p;
    cmd_wdata = d; cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic rsp_handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    cmd_valid = 0; cmd_is_wr = 0; cmd_addr = '0; cmd_prot = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 2'b00;

    // ---------------- reset state ----------------
    #2;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_timeout", rsp_timeout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_cmd_ready_pre_edge", cmd_ready, 0);
    tick();
    chk("rel_cmd_ready", cmd_ready, 1);

    // ---------------- write, zero-wait slave ----------------
    send_cmd(1'b1, 4'h0, 3'b000, 32'h12345678, 4'hF);
    chk("w0_awvalid", axi.awvalid, 1);
    chk("w0_wvalid", axi.wvalid, 1);
    chk("w0_cmd_ready", cmd_ready, 0);
    chk("w0_wdata", axi.wdata, 32'h12345678);
    chk("w0_wstrb", axi.wstrb, 4'hF);
    chk("w0_bready_c1", axi.bready, 0);
    axi.awready = 1; axi.wready = 1;
    tick();
    axi.awready = 0; axi.wready = 0;
    chk("w0_awvalid_c2", axi.awvalid, 0);
    chk("w0_wvalid_c2", axi.wvalid, 0);
    chk("w0_bready_c2", axi.bready, 1);
    axi.bvalid = 1; axi.bresp = 2'b00;
    tick();
    axi.bvalid = 0;
    chk("w0_rsp_valid_c3", rsp_valid, 1);
    chk("w0_resp", rsp_resp, 2'b00);
    chk("w0_is_wr", rsp_is_wr, 1);
    chk("w0_rdata", rsp_rdata, 0);
    chk("w0_bready_c3", axi.bready, 0);
    rsp_handshake();
    chk("w0_rsp_valid_done", rsp_valid, 0);
    chk("w0_cmd_ready_back", cmd_ready, 1);

    // ---------------- write, W delayed, early bvalid held off ----------------
    send_cmd(1'b1, 4'h4, 3'b001, 32'h87654321, 4'hF);
    chk("w1_awvalid_c1", axi.awvalid, 1);
    chk("w1_awaddr", axi.awaddr, 4'h4);
    chk("w1_awprot", axi.awprot, 3'b001);
    axi.awready = 1;
    tick();
    axi.awready = 0;
    chk("w1_awvalid_c2", axi.awvalid, 0);
    chk("w1_wvalid_c2", axi.wvalid, 1);
    axi.bvalid = 1; axi.bresp = 2'b00;
    tick();
    chk("w1_wvalid_c3", axi.wvalid, 1);
    chk("w1_wdata_c3", axi.wdata, 32'h87654321);
    chk("w1_bready_held_c3", axi.bready, 0);
    tick();
    chk("w1_wvalid_c4", axi.wvalid, 1);
    chk("w1_wdata_c4", axi.wdata, 32'h87654321);
    chk("w1_bready_held_c4", axi.bready, 0);
    axi.wready = 1;
    tick();
    axi.wready = 0;
    chk("w1_wvalid_c5", axi.wvalid, 0);
    chk("w1_bready_c5", axi.bready, 1);
    chk("w1_rsp_valid_c5", rsp_valid, 0);
    tick();
    axi.bvalid = 0;
    chk("w1_rsp_valid", rsp_valid, 1);
    chk("w1_resp", rsp_resp, 2'b00);
    chk("w1_bready_off", axi.bready, 0);
    rsp_handshake();

    // ---------------- read, rvalid two cycles after AR ----------------
    send_cmd(1'b0, 4'h8, 3'b010, 32'hFFFFFFFF, 4'hF);
    chk("r0_arvalid", axi.arvalid, 1);
    chk("r0_araddr", axi.araddr, 4'h8);
    chk("r0_arprot", axi.arprot, 3'b010);
    chk("r0_awvalid", axi.awvalid, 0);
    chk("r0_rready_c1", axi.rready, 0);
    axi.arready = 1;
    tick();
    axi.arready = 0;
    chk("r0_arvalid_c2", axi.arvalid, 0);
    chk("r0_rready_c2", axi.rready, 1);
    tick();
    chk("r0_rready_c3", axi.rready, 1);
    chk("r0_rsp_valid_c3", rsp_valid, 0);
    axi.rvalid = 1; axi.rdata = 32'hCAFEF00D; axi.rresp = 2'b00;
    tick();
    axi.rvalid = 0;
    chk("r0_rsp_valid", rsp_valid, 1);
    chk("r0_rdata", rsp_rdata, 32'hCAFEF00D);
    chk("r0_is_wr", rsp_is_wr, 0);
    chk("r0_resp", rsp_resp, 2'b00);
    chk("r0_rready_off", axi.rready, 0);
    rsp_handshake();

    // ---------------- SLVERR response held under backpressure ----------------
    send_cmd(1'b1, 4'h0, 3'b000, 32'hA5A5A5A5, 4'h3);
    chk("w2_wstrb", axi.wstrb, 4'h3);
    axi.awready = 1; axi.wready = 1;
    tick();
    axi.awready = 0; axi.wready = 0;
    axi.bvalid = 1; axi.bresp = 2'b10;
    tick();
    axi.bvalid = 0;
    // Next command waits while the response is stalled.
    cmd_valid = 1; cmd_is_wr = 0; cmd_addr = 4'hC; cmd_prot = 3'b000;
    for (int i = 0; i < 5; i++) begin
      chk("w2_hold_rsp_valid", rsp_valid, 1);
      chk("w2_hold_resp", rsp_resp, 2'b10);
      chk("w2_hold_cmd_ready", cmd_ready, 0);
      tick();
    end
    chk("w2_hold_arvalid", axi.arvalid, 0);
    rsp_handshake();
    chk("w2_after_rsp_valid", rsp_valid, 0);
    chk("w2_after_cmd_ready", cmd_ready, 1);
    chk("w2_after_arvalid", axi.arvalid, 0);
    tick();
    cmd_valid = 0;
    chk("r1_arvalid", axi.arvalid, 1);
    chk("r1_araddr", axi.araddr, 4'hC);
    chk("r1_cmd_ready", cmd_ready, 0);
    axi.arready = 1;
    tick();
    axi.arready = 0;
    axi.rvalid = 1; axi.rdata = 32'h0BADBEEF; axi.rresp = 2'b11;
    tick();
    axi.rvalid = 0;
    chk("r1_rsp_valid", rsp_valid, 1);
    chk("r1_resp_decerr", rsp_resp, 2'b11);
    chk("r1_rdata", rsp_rdata, 32'h0BADBEEF);
    rsp_handshake();

    // ---------------- async reset mid-write ----------------
    send_cmd(1'b1, 4'h4, 3'b011, 32'h11223344, 4'hF);
    axi.awready = 1;
    tick();
    axi.awready = 0;
    chk("rw_awvalid_done", axi.awvalid, 0);
    chk("rw_wvalid_pending", axi.wvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_wvalid_async", axi.wvalid, 0);
    chk("rw_wdata_async", axi.wdata, 0);
    chk("rw_awaddr_async", axi.awaddr, 0);
    chk("rw_awprot_async", axi.awprot, 0);
    chk("rw_cmd_ready_async", cmd_ready, 0);
    chk("rw_bready_async", axi.bready, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    axi.wready = 1; axi.bvalid = 1; axi.bresp = 2'b01;
    tick();
    chk("rw_cmd_ready_rel", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      chk("rw_no_stale_rsp", rsp_valid, 0);
      chk("rw_no_bready", axi.bready, 0);
      tick();
    end
    axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;

    chk("cnt_rsp_handshakes", n_rsp, 5);
    chk("cnt_b_handshakes", n_b, 3);
    chk("no_timeout_flag", rsp_timeout, 0);

`ifdef AXI4_LITE_CMD_MST_TIMEOUT_EN
    // ---------------- watchdog: arready never asserted ----------------
    begin
      int n_ar;
      n_ar = 0;
      send_cmd(1'b0, 4'h0, 3'b000, 32'h0, 4'h0);
      for (int i = 0; i < 20; i++) begin
        if (axi.arvalid) n_ar++;
        tick();
      end
      chk("to_arvalid_cycles", n_ar, TO);
      chk("to_arvalid_off", axi.arvalid, 0);
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_resp", rsp_resp, 2'b10);
      chk("to_flag", rsp_timeout, 1);
      chk("to_rdata", rsp_rdata, 0);
      rsp_handshake();
      chk("to_cmd_ready", cmd_ready, 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi4_lite_cmd_mst.md
# axi4_lite_cmd_mst

Synthesizable AXI4-Lite master that turns a simple command/response stream into single AXI4-Lite read or write transactions. It has parametrised address and data widths and full byte-strobe support. The AW and W channels complete independently, and an optional watchdog bounds how long a transaction may stay outstanding. It sits between register-access logic (sequencers, CPU-less init engines, testbench drivers) and any AXI4-Lite slave such as `my_axi4_lite_slv_template`.

## Interface
Parameters:
- AXI4_LITE_ADDR_BIT_WIDTH, 4, address bus width (≥2)
- AXI4_LITE_DATA_BIT_WIDTH, 32, data bus width (32 or 64)
- TIMEOUT_CYCLES, 256, watchdog limit in clock cycles (≥2; used only with the macro)

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_async_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command ready
- i_cmd_is_wr  in  1  1 = write, 0 = read
- i_cmd_addr  in  ADDR_BIT_WIDTH  byte address
- i_cmd_prot  in  3  AxPROT value
- i_cmd_wdata  in  DATA_BIT_WIDTH  write data (ignored for reads)
- i_cmd_wstrb  in  DATA_BIT_WIDTH/8  write strobes (ignored for reads)
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response ready
- o_rsp_is_wr  out  1  response belongs to a write
- o_rsp_rdata  out  DATA_BIT_WIDTH  read data (0 for writes)
- o_rsp_resp  out  2  BRESP/RRESP, or SLVERR on timeout
- o_rsp_timeout  out  1  transaction abandoned by the watchdog
- if_m_axi4_lite  axi4_lite_if.mst_port  —  AXI4-Lite master port; interface widths equal the parameters

## Operation
- One transaction is outstanding at a time. The FSM states are IDLE, WR_AW_W, WR_B, RD_AR, RD_R and RSP.
- o_cmd_ready is a registered output, high only in IDLE.
- IDLE: when i_cmd_valid && o_cmd_ready, capture the command.
  - Write → WR_AW_W with awvalid=wvalid=1.
  - Read → RD_AR with arvalid=1.
- WR_AW_W: aw_done and w_done flags track the two handshakes independently.
  - Each valid drops the cycle after its own handshake.
  - awaddr, awprot, wdata and wstrb stay stable while their valid is high.
  - When both flags are set → WR_B.
- WR_B: bready=1. On bvalid, latch bresp and go → RSP.
- RD_AR: hold arvalid with a stable araddr/arprot. On arready → RD_R.
- RD_R: rready=1. On rvalid, latch rdata and rresp, then go → RSP.
- RSP: o_rsp_valid=1 and the response fields are held stable. On i_rsp_ready → IDLE.
- bready and rready are low outside WR_B and RD_R. A slave that asserts bvalid or rvalid early is simply held off.
- Response codes pass through unmodified (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11).
- Reset, asynchronous:
  - All outputs go to 0 immediately: valids, readies, o_cmd_ready, o_rsp_*, and all address/data outputs.
  - The state returns to IDLE and any in-flight transaction and pending response are discarded.
  - o_cmd_ready rises on the first i_clk edge after reset deassertion.

## Timing
- Command-accept edge = cycle 0. AW/W (or AR) valids are high from cycle 1.
- Best case with a zero-wait slave:
  - Write: AW+W handshake at cycle 1, B at cycle 2, o_rsp_valid at cycle 3.
  - Read: AR at cycle 1, R at cycle 2, o_rsp_valid at cycle 3.
- Back-to-back: the next command is accepted the cycle after the response handshake. Minimum period is 4 cycles per transaction.
- AW and W handshakes in the same cycle are legal, as are either order with arbitrary gaps.
- There are no combinational paths from any input to any output.

## Configuration
- AXI4_LITE_CMD_MST_TIMEOUT_EN defined:
  - A counter clears on entry to WR_AW_W or RD_AR and increments every cycle in WR_AW_W, WR_B, RD_AR and RD_R.
  - When the counter equals TIMEOUT_CYCLES-1, the next edge drops all AXI valids and readies and goes → RSP with o_rsp_resp=2'b10, o_rsp_timeout=1 and o_rsp_rdata=0.
  - This abandons the bus transaction; it is a debug aid only.
- Not defined: no counter exists, o_rsp_timeout is tied 0, and the block waits on the slave indefinitely.

## Structure
- Package axi4_lite_cmd_mst_pkg holds:
  - the FSM state enum;
  - the resp-code localparams (RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR);
  - width-parametrised cmd/rsp struct typedefs, via a parametrised class or typedef macros.
- One sub-module, axi4_lite_cmd_mst_wdog: the timeout counter with clear, enable and expire signals. It is instantiated only under the macro.

## Test plan
- Write addr 0x0, data 0x12345678, strb 0xF to a zero-wait slave → awvalid and wvalid high at cycle 1, bready at cycle 2, o_rsp_valid at cycle 3 with resp 2'b00 and is_wr=1.
- Write addr 0x4, data 0x87654321, with awready at cycle 1 and wready delayed to cycle 4 → awvalid low from cycle 2, wvalid/wdata stable through cycle 4, exactly one B and one response.
- Read addr 0x8, slave arready at cycle 1 and rvalid 2 cycles later with rdata 0xCAFEF00D and rresp 2'b00 → o_rsp_rdata 0xCAFEF00D and is_wr=0.
- Hold i_rsp_ready low 5 cycles after a response with bresp 2'b10 → o_rsp_valid and resp 2'b10 stay stable and o_cmd_ready stays 0. A new command is accepted the cycle after the handshake.
- With the macro and TIMEOUT_CYCLES=16, a slave that never asserts arready → arvalid drops after 16 cycles, then the response has resp 2'b10 and timeout=1.
- Assert i_async_rst_n low mid-write with AW done and W pending → all outputs 0 without waiting for an edge. After release, o_cmd_ready=1 after one edge and no stale response appears.
